// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity frame transmitter.
package parity_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_PARITY} tx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_tx_fifo.sv
// Small synchronous FIFO with extra-bit pointers so full/empty need no flag registers.
module parity_tx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import parity_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Buffers parallel words and shifts each out LSB-first followed by one parity bit.
module parity_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              data,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy,
  output logic [5:0]        frame_count
);
  import parity_pkg::*;

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  tx_state_e         state;
  logic [DATA_W-1:0] shift, fifo_q;
  logic [CW-1:0]     bit_cnt;
  logic              acc, push, pop, full, empty;
  logic [AW:0]       count;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  // Pop only at a frame boundary; the parity slot doubles as the reload cycle.
  assign pop      = !empty && (state == TX_IDLE || state == TX_PARITY);
  assign busy     = (state != TX_IDLE) || (count != '0);

  parity_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_q),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= TX_IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      acc         <= 1'b0;
      data        <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          data        <= 1'b0;
          bit_valid   <= 1'b0;
          frame_start <= 1'b0;
          frame_end   <= 1'b0;
          if (!empty) begin
            shift   <= fifo_q;
            bit_cnt <= '0;
            acc     <= PARITY_ODD;
            state   <= TX_DATA;
          end
        end
        TX_DATA: begin
          data        <= shift[0];
          bit_valid   <= 1'b1;
          frame_start <= (bit_cnt == '0);
          frame_end   <= 1'b0;
          shift       <= shift >> 1;
          acc         <= acc ^ shift[0];
          bit_cnt     <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATA_W-1)) state <= TX_PARITY;
        end
        TX_PARITY: begin
          data        <= acc;
          bit_valid   <= 1'b1;
          frame_start <= 1'b0;
          frame_end   <= 1'b1;
          frame_count <= frame_count + 6'd1;
          if (!empty) begin
            shift   <= fifo_q;
            bit_cnt <= '0;
            acc     <= PARITY_ODD;
            state   <= TX_DATA;
          end else begin
            state   <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule
